// File: rtl/controlador_conteo_if.sv
// Bundle of signals shared between the count controller, the host that
// issues start/abort, and the 4-bit enable/clear counter it drives.
interface controlador_conteo_if #(
    parameter int W = 4
);
    logic         start;
    logic         abort;
    logic         mode;
    logic [W-1:0] target;
    logic [W-1:0] q_in;
    logic         en;
    logic         clr;
    logic         busy;
    logic         done;
    logic         err;

    // Controller side: drives the counter controls and status
    modport master (
        input  start, abort, mode, target, q_in,
        output en, clr, busy, done, err
    );

    // Host/counter side: issues requests, returns Q, observes status
    modport slave (
        output start, abort, mode, target, q_in,
        input  en, clr, busy, done, err
    );
endinterface

// File: rtl/controlador_conteo.sv
// Control-side master for an enable/clear counter: clears it, lets it count
// up to a latched target, checks every read-back value against the expected
// sequence and reports done (pulse) or a sticky error.
module controlador_conteo #(
    parameter int W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    controlador_conteo_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        COUNT = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [W-1:0] ONE = W'(1);

    state_t       state_q, state_d;
    logic [W-1:0] tgt_q, tgt_d;
    logic         mode_q, mode_d;
    logic [W-1:0] exp_q, exp_d;
    logic         err_q, err_d;
    logic [W-1:0] tgt_m1;
    logic         go;

    // A run request only counts when abort is not asserted alongside it
    assign go     = bus.start && !bus.abort;
    // Only meaningful in COUNT, where the latched target is at least 1
    assign tgt_m1 = tgt_q - ONE;

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            mode_q  <= 1'b0;
            exp_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            mode_q  <= mode_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: sequencing, target/mode latching and sequence check
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        mode_d  = mode_q;
        exp_d   = exp_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    tgt_d   = bus.target;
                    mode_d  = bus.mode;
                    err_d   = 1'b0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                // Counter is zeroed at this edge, so the first expected Q is 0
                exp_d = '0;
                if (bus.abort)         state_d = IDLE;
                else if (tgt_q == '0)  state_d = DONE;
                else                   state_d = COUNT;
            end
            COUNT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.q_in != exp_q) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end else if (bus.q_in == tgt_m1) begin
                    // The increment at this edge lands Q exactly on the target
                    state_d = DONE;
                end else begin
                    exp_d = exp_q + ONE;
                end
            end
            DONE: begin
                if (mode_q && !bus.abort) begin
                    state_d = CLEAR;
                end else if (go) begin
                    tgt_d   = bus.target;
                    mode_d  = bus.mode;
                    state_d = CLEAR;
                end else begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (go) begin
                    tgt_d   = bus.target;
                    mode_d  = bus.mode;
                    err_d   = 1'b0;
                    state_d = CLEAR;
                end else if (bus.abort) begin
                    // Leaving via abort keeps the error visible to the host
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from state only, so reset drops them at once
    always_comb begin
        bus.en   = (state_q == CLEAR) || (state_q == COUNT);
        bus.clr  = (state_q == CLEAR);
        bus.busy = (state_q == CLEAR) || (state_q == COUNT);
        bus.done = (state_q == DONE);
        bus.err  = err_q;
    end

endmodule

// File: tb/tb_controlador_conteo.sv
// Directed bench for controlador_conteo with a behavioural 4-bit counter
// closing the EN/CLR -> Q loop.
module tb_controlador_conteo;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] cnt_q = 4'd0;
    logic       force_en  = 1'b0;
    logic [3:0] force_val = 4'd0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_clr   = 0;

    controlador_conteo_if #(.W(4)) bus ();

    controlador_conteo #(.W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural enable/clear counter; q_in can be overridden for fault injection
    always @(posedge clk) begin
        if (bus.clr)     cnt_q <= 4'd0;
        else if (bus.en) cnt_q <= cnt_q + 4'd1;
    end
    assign bus.q_in = force_en ? force_val : cnt_q;

    typedef struct {
        logic       start;
        logic       abort;
        logic       mode;
        logic [3:0] target;
        logic [4:0] outs;   // {en, clr, busy, done, err}
        logic [3:0] q;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic a, input logic m, input logic [3:0] t,
                       input logic [4:0] o, input logic [3:0] q);
        vec_t v;
        v.start = s; v.abort = a; v.mode = m; v.target = t; v.outs = o; v.q = q;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int outs();
        return int'({bus.en, bus.clr, bus.busy, bus.done, bus.err});
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int eq;
        bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 1'b0; bus.target = 4'd0;

        // Reset: outputs low without any clock edge
        #2 rst_n = 1'b0;
        #1 chk("reset_outs", outs(), 0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("post_reset_outs", outs(), 0);

        // Table: single run to 5, target 0, start+abort, abort mid-run,
        // start/target/mode changes ignored mid-run
        add(1'b1,1'b0,1'b0,4'd5,  5'b11100, 4'd0);  // CLEAR
        add(1'b0,1'b0,1'b0,4'd5,  5'b10100, 4'd0);  // COUNT
        add(1'b0,1'b0,1'b0,4'd5,  5'b10100, 4'd1);
        add(1'b0,1'b0,1'b0,4'd5,  5'b10100, 4'd2);
        add(1'b0,1'b0,1'b0,4'd5,  5'b10100, 4'd3);
        add(1'b0,1'b0,1'b0,4'd5,  5'b10100, 4'd4);
        add(1'b0,1'b0,1'b0,4'd5,  5'b00010, 4'd5);  // DONE
        add(1'b0,1'b0,1'b0,4'd5,  5'b00000, 4'd5);  // IDLE, Q holds
        add(1'b1,1'b0,1'b0,4'd0,  5'b11100, 4'd5);  // CLEAR
        add(1'b0,1'b0,1'b0,4'd0,  5'b00010, 4'd0);  // DONE directly
        add(1'b0,1'b0,1'b0,4'd0,  5'b00000, 4'd0);  // IDLE
        add(1'b1,1'b1,1'b0,4'd7,  5'b00000, 4'd0);  // start+abort: stays IDLE
        add(1'b1,1'b0,1'b0,4'd10, 5'b11100, 4'd0);  // CLEAR
        add(1'b0,1'b0,1'b0,4'd10, 5'b10100, 4'd0);
        add(1'b1,1'b0,1'b1,4'd2,  5'b10100, 4'd1);  // ignored start/target/mode
        add(1'b1,1'b0,1'b1,4'd2,  5'b10100, 4'd2);
        add(1'b0,1'b0,1'b0,4'd10, 5'b10100, 4'd3);
        add(1'b0,1'b1,1'b0,4'd10, 5'b00000, 4'd4);  // abort: IDLE, Q=4, no done
        add(1'b0,1'b0,1'b0,4'd10, 5'b00000, 4'd4);

        foreach (vecs[i]) begin
            bus.start  = vecs[i].start;
            bus.abort  = vecs[i].abort;
            bus.mode   = vecs[i].mode;
            bus.target = vecs[i].target;
            step();
            chk($sformatf("vec%0d_outs", i), outs(), int'(vecs[i].outs));
            chk($sformatf("vec%0d_q", i), int'(cnt_q), int'(vecs[i].q));
        end

        // Full-range run to 15: no wrap, no error
        bus.start = 1'b1; bus.target = 4'd15; bus.mode = 1'b0;
        step();
        chk("t15_clear", outs(), 5'b11100);
        bus.start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            chk($sformatf("t15_q%0d", k), int'(cnt_q), k);
            chk($sformatf("t15_o%0d", k), outs(), 5'b10100);
        end
        step();
        chk("t15_done", outs(), 5'b00010);
        chk("t15_q", int'(cnt_q), 15);
        step();
        chk("t15_idle", outs(), 0);

        // Auto-repeat, target 3: period of 5 cycles (CLEAR, 3x COUNT, DONE)
        bus.start = 1'b1; bus.target = 4'd3; bus.mode = 1'b1;
        n_done = 0; n_clr = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            bus.start = 1'b0;
            p = k % 5;
            if (bus.done) n_done++;
            if (bus.clr)  n_clr++;
            chk($sformatf("rep_clr%0d", k), int'(bus.clr), (p == 0) ? 1 : 0);
            chk($sformatf("rep_done%0d", k), int'(bus.done), (p == 4) ? 1 : 0);
            if (p == 0)      eq = (k == 0) ? 15 : 3;
            else if (p == 4) eq = 3;
            else             eq = p - 1;
            chk($sformatf("rep_q%0d", k), int'(cnt_q), eq);
        end
        chk("rep_ndone", n_done, 3);
        chk("rep_nclr", n_clr, 3);
        bus.abort = 1'b1;
        step();
        chk("rep_abort_idle", outs(), 0);
        bus.abort = 1'b0; bus.mode = 1'b0;

        // Error injection: Q reads 7 while 2 is expected
        bus.start = 1'b1; bus.target = 4'd9;
        step();
        bus.start = 1'b0;
        step(); step(); step();
        chk("err_pre_q", int'(cnt_q), 2);
        force_en = 1'b1; force_val = 4'd7;
        step();
        force_en = 1'b0;
        chk("err_enter", outs(), 5'b00001);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("err_hold%0d", k), outs(), 5'b00001);
            chk($sformatf("err_q%0d", k), int'(cnt_q), 3);
        end
        bus.start = 1'b1; bus.target = 4'd2;
        step();
        bus.start = 1'b0;
        chk("err_restart", outs(), 5'b11100);
        step(); chk("err_r_q0", int'(cnt_q), 0);
        step(); chk("err_r_q1", int'(cnt_q), 1);
        step();
        chk("err_r_done", outs(), 5'b00010);
        chk("err_r_q2", int'(cnt_q), 2);
        step();

        // Asynchronous reset in the middle of a run
        bus.start = 1'b1; bus.target = 4'd12;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 7; k++) step();
        chk("rst_mid_q", int'(cnt_q), 6);
        chk("rst_mid_busy", int'(bus.busy), 1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_outs", outs(), 0);
        #1 rst_n = 1'b1;
        step();
        chk("rst_after_idle", outs(), 0);
        chk("rst_after_q", int'(cnt_q), 6);

        // Start during COUNT is ignored; mode not relatched
        bus.start = 1'b1; bus.target = 4'd5; bus.mode = 1'b0;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("ign_q3", int'(cnt_q), 3);
        bus.start = 1'b1; bus.target = 4'd1; bus.mode = 1'b1;
        step();
        bus.start = 1'b0;
        chk("ign_q4", int'(cnt_q), 4);
        chk("ign_busy", outs(), 5'b10100);
        step();
        chk("ign_done", outs(), 5'b00010);
        chk("ign_q5", int'(cnt_q), 5);
        step();
        chk("ign_idle", outs(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/controlador_conteo.md
Name: controlador_conteo

Overview:
- Control-side master for a 4-bit enable/clear counter: generates that counter's EN and CLR inputs and reads back its Q.
- On a start request it clears the counter, then lets it count up to a programmed target and stops it there. It reports done, and raises a sticky error if the counter output does not follow the expected sequence.
- Sits between a host/FSM issuing start/abort and one counter instance; only the interface is shared, the counter itself is unchanged.

Parameters:
W, 4, counter width; width of target and q_in.

Ports:
clk     in   1  system clock, all state on rising edge
rst_n   in   1  asynchronous active-low reset
start   in   1  request a run; sampled only in IDLE, DONE or ERR
abort   in   1  stop current run and return to IDLE
mode    in   1  0 = single run, 1 = auto-repeat; latched with start
target  in   W  final count value; latched with start
q_in    in   W  counter output Q (read-back)
en      out  1  to counter EN
clr     out  1  to counter CLR
busy    out  1  high in CLEAR and COUNT
done    out  1  one-cycle pulse per completed run
err     out  1  sticky sequence-mismatch flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE, tgt_r=0, mode_r=0, exp_r=0, err=0. en, clr, busy and done are low immediately, because they are decoded from state only (Moore).
- States, with outputs en/clr/busy/done/err-set:
  - IDLE 0/0/0/0
  - CLEAR 1/1/1/0
  - COUNT 1/0/1/0
  - DONE 0/0/0/1
  - ERR 0/0/0/0, with err held at 1
- IDLE:
  - start=1 and abort=0: latch tgt_r<=target, mode_r<=mode, clear err, go to CLEAR.
  - Otherwise stay in IDLE.
- CLEAR (exactly 1 cycle; the counter is zeroed at this edge):
  - exp_r<=0.
  - abort -> IDLE.
  - tgt_r==0 -> DONE.
  - Else -> COUNT.
- COUNT (one counter increment per cycle):
  - Each cycle compare q_in with exp_r.
  - Mismatch -> ERR, err<=1.
  - Else if q_in==tgt_r-1 -> DONE; the final increment at this edge leaves Q=tgt_r.
  - Else exp_r<=exp_r+1 and stay in COUNT.
  - Priority: abort > mismatch > completion.
  - COUNT therefore lasts tgt_r cycles; total latency from start sampled to done high is tgt_r+2 cycles.
- DONE (1 cycle):
  - mode_r=1 and abort=0 -> CLEAR (auto-repeat, restarts from 0).
  - Else if start=1 and abort=0 -> relatch target/mode, -> CLEAR.
  - Else -> IDLE.
  - Q holds tgt_r while en=0.
- ERR:
  - en=0 freezes the counter.
  - Stays until start=1 and abort=0, which clears err, relatches target/mode and goes to CLEAR.
  - abort alone -> IDLE with err still 1.
- Ignored inputs:
  - start during CLEAR/COUNT is ignored; target and mode changes mid-run have no effect.
  - start and abort together: abort wins, no run starts.
- Width rules:
  - exp_r is W bits; tgt_r ranges 0..2^W-1; the final value is never above 2^W-1, so no wrap occurs inside a run.
  - tgt_r-1 is computed in W bits and is only evaluated in COUNT, where tgt_r>=1.
- Mid-operation events:
  - abort mid-run: counter stays at the last value, no done pulse.
  - rst_n low mid-run: en/clr drop asynchronously, no done pulse.

Test Plan:
1. Reset with rst_n=0 then release; start=1 with target=5, mode=0 -> clr=en=1 for 1 cycle, then en=1 for 5 cycles. Q goes 0,1,2,3,4,5; done pulses once on cycle 7 after start; Q holds 5; busy low afterwards.
2. target=0 and target=15, mode=0 -> target=0: CLEAR then DONE, Q=0, done at cycle 2. Target=15: 15 COUNT cycles, Q=15, no wrap, err=0.
3. target=3, mode=1 for three runs -> Q sequence 0,1,2,3,0,1,2,3,...; done pulses every 5 cycles; clr high once per run.
4. target=10, assert abort when Q=4 -> next cycle IDLE, en=0, Q stays 4, no done. Start+abort together in IDLE -> stays IDLE.
5. Error injection: bench forces q_in=7 when 2 is expected (target=9) -> ERR next cycle, en=0, err=1 and stays 1. Later start=1 clears err and begins a new run from CLEAR.
6. Assert rst_n=0 mid-COUNT (target=12, Q=6) -> en, clr and busy drop without waiting for clk. After release, IDLE; start ignored during COUNT in a follow-up run (second start at Q=3 does not restart).
